// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-host bus of the UART receive FIFO: byte strobe in, show-ahead
// head entry, status flags and interrupts out.
interface uart_rx_fifo_if #(
    parameter int AW = 4
);
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        bd8_rate;
    logic        rd_en;
    logic        ovr_clr;
    logic [7:0]  rd_data;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        thresh_irq;
    logic        timeout_irq;
    logic        overrun;

    modport master (
        output rx_data, rx_rdy, bd8_rate, rd_en, ovr_clr,
        input  rd_data, empty, full, count, thresh_irq, timeout_irq, overrun
    );

    modport slave (
        input  rx_data, rx_rdy, bd8_rate, rd_en, ovr_clr,
        output rd_data, empty, full, count, thresh_irq, timeout_irq, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: DEPTH-entry show-ahead FIFO with fill-threshold
// interrupt, sticky overrun flag and character-idle timeout.
module uart_rx_fifo #(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int THRESH     = 8,
    parameter int IDLE_TICKS = 320
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave bus
);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   THRESH_C = (AW+1)'(THRESH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [9:0]    IDLE_C   = 10'(IDLE_TICKS);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic [9:0]    idle;
    logic          empty_q;
    logic          full_q;
    logic          thresh_q;
    logic          timeout_q;
    logic          overrun_q;
    logic          push;
    logic          pop;
    logic          drop;

    // A write into a full FIFO is accepted only when the same-cycle pop frees a slot.
    always_comb begin
        pop       = bus.rd_en && !empty_q;
        push      = bus.rx_rdy && (!full_q || bus.rd_en);
        drop      = bus.rx_rdy && full_q && !bus.rd_en;
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (pop && !push) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wp] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            thresh_q <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + PTR_ONE;
            end
            if (pop) begin
                rp <= rp + PTR_ONE;
            end
            count    <= count_nxt;
            empty_q  <= (count_nxt == '0);
            full_q   <= (count_nxt == DEPTH_C);
            thresh_q <= (count_nxt >= THRESH_C);
        end
    end

    // Idle timer only runs while data sits untouched in the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle      <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (push || pop || count == '0) begin
                idle <= '0;
            end else if (bus.bd8_rate && idle != IDLE_C) begin
                idle <= idle + 10'd1;
            end
            timeout_q <= (idle == IDLE_C);
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (bus.ovr_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.rd_data     = mem[rp];
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.count       = count;
    assign bus.thresh_irq  = thresh_q;
    assign bus.timeout_irq = timeout_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: vector table, directed corner sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH      = 16;
    localparam int AW         = 4;
    localparam int THRESH     = 8;
    localparam int IDLE_TICKS = 320;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.AW(AW)) bus ();

    uart_rx_fifo #(
        .DEPTH(DEPTH), .AW(AW), .THRESH(THRESH), .IDLE_TICKS(IDLE_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [7:0] q[$];
    bit         m_ovr;
    int         m_idle;
    bit         m_to;

    typedef struct {
        bit         rdy;
        logic [7:0] d;
        bit         rd;
        bit         clr;
        int         e_count;
        bit         e_empty;
        logic [7:0] e_data;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("empty", 32'(bus.empty), 32'(q.size() == 0));
        chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
        chk("thresh_irq", 32'(bus.thresh_irq), 32'(q.size() >= THRESH));
        chk("timeout_irq", 32'(bus.timeout_irq), 32'(m_to));
        chk("overrun", 32'(bus.overrun), 32'(m_ovr));
        if (q.size() > 0) chk("rd_data", 32'(bus.rd_data), 32'(q[0]));
    endtask

    task automatic step(input bit rdy, input logic [7:0] d, input bit rd, input bit clr, input bit tick);
        bit pop_ok;
        bit push_ok;
        int old_n;
        bus.rx_rdy   = rdy;
        bus.rx_data  = d;
        bus.rd_en    = rd;
        bus.ovr_clr  = clr;
        bus.bd8_rate = tick;
        old_n   = q.size();
        pop_ok  = rd && old_n > 0;
        push_ok = rdy && (old_n < DEPTH || rd);
        @(posedge clk);
        #1;
        m_to = (m_idle == IDLE_TICKS);
        if (push_ok || pop_ok || old_n == 0) m_idle = 0;
        else if (tick && m_idle < IDLE_TICKS) m_idle++;
        if (rdy && !push_ok) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        if (pop_ok) void'(q.pop_front());
        if (push_ok) q.push_back(d);
        bus.rx_rdy   = 1'b0;
        bus.rd_en    = 1'b0;
        bus.ovr_clr  = 1'b0;
        bus.bd8_rate = 1'b0;
        check_model();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_data"}, 32'(bus.rd_data), 32'h00);
        chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
        chk({tag, "_full"}, 32'(bus.full), 32'd0);
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_thresh"}, 32'(bus.thresh_irq), 32'd0);
        chk({tag, "_timeout"}, 32'(bus.timeout_irq), 32'd0);
        chk({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
    endtask

    task automatic clear_model();
        q.delete();
        m_ovr  = 1'b0;
        m_idle = 0;
        m_to   = 1'b0;
    endtask

    task automatic do_reset();
        bus.rx_rdy   = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rd_en    = 1'b0;
        bus.ovr_clr  = 1'b0;
        bus.bd8_rate = 1'b0;
        rst = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b1;
    endtask

    initial begin
        vt[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 8'hA5};
        vt[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h00};
        vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h00};
        vt[3]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 8'h11};
        vt[4]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 8'h11};
        vt[5]  = '{1'b1, 8'h33, 1'b0, 1'b0, 3, 1'b0, 8'h11};
        vt[6]  = '{1'b1, 8'h44, 1'b0, 1'b0, 4, 1'b0, 8'h11};
        vt[7]  = '{1'b1, 8'h55, 1'b0, 1'b0, 5, 1'b0, 8'h11};
        vt[8]  = '{1'b1, 8'h66, 1'b1, 1'b0, 5, 1'b0, 8'h22};
        vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4, 1'b0, 8'h33};
        vt[10] = '{1'b1, 8'h77, 1'b1, 1'b0, 4, 1'b0, 8'h44};
        vt[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 3, 1'b0, 8'h55};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            step(vt[i].rdy, vt[i].d, vt[i].rd, vt[i].clr, 1'b0);
            chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vt[i].e_count));
            chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(vt[i].e_empty));
            if (!vt[i].e_empty) chk($sformatf("vec%0d_data", i), 32'(bus.rd_data), 32'(vt[i].e_data));
        end

        // fill 0x00..0x0F from reset, drain in order, pointers wrap to 0
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            chk($sformatf("fill%0d_thresh", i), 32'(bus.thresh_irq), 32'(i >= 7));
        end
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_count", 32'(bus.count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_data", i), 32'(bus.rd_data), 32'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        chk("wrap_data", 32'(bus.rd_data), 32'h55);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // full-FIFO corner cases
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("drop_overrun", 32'(bus.overrun), 32'd1);
        chk("drop_count", 32'(bus.count), 32'd16);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("clr_overrun", 32'(bus.overrun), 32'd0);
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        chk("clr_vs_drop", 32'(bus.overrun), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        chk("full_pushpop_ovr", 32'(bus.overrun), 32'd0);
        chk("full_pushpop_count", 32'(bus.count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("full_drain%0d", i), 32'(bus.rd_data), (i < 15) ? 32'(8'hB1 + i) : 32'h77);
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end

        // idle timeout with one byte held, bd8_rate every 10 clocks
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < IDLE_TICKS; t++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            if (t == IDLE_TICKS - 1) chk("to_pre", 32'(bus.timeout_irq), 32'd0);
            for (int k = 0; k < 9; k++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        chk("to_rise", 32'(bus.timeout_irq), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("to_fall", 32'(bus.timeout_irq), 32'd0);
        for (int t = 0; t < 400; t++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            for (int k = 0; k < 9; k++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        chk("to_empty", 32'(bus.timeout_irq), 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 9) < 3,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0);
        end

        // async reset mid-stream with count=9 and overrun=1
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(bus.count), 32'd9);
        chk("pre_rst_overrun", 32'(bus.overrun), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("async");
        clear_model();
        @(posedge clk);
        #2;
        rst = 1'b1;
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("post_rst_data", 32'(bus.rd_data), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer between the UART receiver (`rx`) and the host-side consumer. It captures every byte the receiver strobes out on `rx_data`/`rx_rdy` into a DEPTH-entry FIFO and presents the oldest byte show-ahead. It generates a fill-threshold interrupt, a sticky overrun flag, and a character-idle timeout counted in `bd8_rate` ticks from `baud_rate_en`.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 4.
- `AW`, 4: pointer width, log2(DEPTH).
- `THRESH`, 8: `thresh_irq` level, 1..DEPTH.
- `IDLE_TICKS`, 320: `bd8_rate` ticks with no push/pop before `timeout_irq` (≈4 frames at 8x); `IDLE_TICKS` < 1024.

Ports:
- `clk` in 1: sole clock; everything is posedge.
- `rst` in 1: asynchronous, active-low reset; deassertion is synchronous to `clk` at system level.
- `bd8_rate` in 1: one-cycle 8x-oversample enable from `baud_rate_en`.
- `rx_data` in 8: received byte from `rx`.
- `rx_rdy` in 1: one-cycle strobe; `rx_data` valid this cycle.
- `rd_en` in 1: pop head entry.
- `ovr_clr` in 1: clear `overrun`.
- `rd_data` out 8: head entry; valid while `empty`=0.
- `empty` out 1, `full` out 1.
- `count` out AW+1: occupancy, 0..DEPTH.
- `thresh_irq` out 1: `count` ≥ THRESH.
- `timeout_irq` out 1: data idle in FIFO.
- `overrun` out 1: sticky byte-dropped flag.

## Operation
- Storage: DEPTH×8 register array. Write pointer `wp` and read pointer `rp` are AW bits and wrap modulo DEPTH. `count` is held as a separate register.
- Push: `rx_rdy`=1 and (`full`=0, or `rd_en`=1 with `full`=1). Write `rx_data` at `wp`, then `wp`+1.
- Pop: `rd_en`=1 and `empty`=0. Advance `rp`+1. `rd_en` on an empty FIFO is ignored, with no pointer or flag change.
- Simultaneous push and pop:
  - Both execute and `count` is unchanged.
  - When empty, only the push occurs.
  - When full, the pop frees a slot and the push succeeds with no overrun.
- Push while full without pop: the byte is dropped, pointers are unchanged, and `overrun` is set.
- Overrun clear: `ovr_clr` clears `overrun`. If a drop occurs in the same cycle as `ovr_clr`, set wins.
- Idle timeout: 10-bit counter `idle`.
  - Reset to 0 on any push, any pop, or `count`=0.
  - Otherwise increments on `bd8_rate` and saturates at IDLE_TICKS.
  - `timeout_irq` = (`idle` == IDLE_TICKS), registered. It falls on the clock after the next push or pop.
- Reset (`rst`=0) drives, asynchronously:
  - `wp`=`rp`=0, `count`=0, `idle`=0, array cleared to 0.
  - Outputs: `rd_data`=0x00, `empty`=1, `full`=0, `thresh_irq`=0, `timeout_irq`=0, `overrun`=0.
  - Assertion mid-operation discards all contents immediately.

## Timing
- All flags (`empty`, `full`, `count`, `thresh_irq`, `timeout_irq`, `overrun`) are registered and reflect an edge's push/pop from that edge onward (1-cycle latency from strobe to visible flag).
- `rd_data` = array[`rp`] combinational from registers. A byte pushed at edge N is visible on `rd_data` after edge N when the FIFO was empty. After a pop at edge N, the next entry is visible after edge N.
- `rx_rdy` is never back-to-back in practice (≥ 80 cycles apart at 8x). The block nonetheless accepts a push every cycle.
- No backpressure to `rx`: the receiver never stalls, and loss is reported only via `overrun`.
- Throughput: one push and one pop per cycle.

## Test plan
- Reset then push 0xA5: after that edge `empty`=0, `count`=1, and `rd_data`=0xA5. Pop gives `empty`=1 and `count`=0.
- Push 16 bytes 0x00..0x0F, pop all: data returns in order. `thresh_irq` rises on the 8th push. `full`=1 at 16. Both pointers wrap to 0, and a 17th byte 0x55 later reads back correctly.
- Full FIFO:
  - Push 0xEE without pop: dropped, `overrun`=1, and `count` stays 16.
  - Push 0x77 with `rd_en` in the same cycle: accepted with no overrun, and 0x77 is last out.
  - `ovr_clr` clears `overrun`, but loses to a simultaneous drop.
- One byte held with `bd8_rate` pulsing every 10 clocks: `timeout_irq` rises after the 320th tick. A pop clears it next cycle. With an empty FIFO, 400 ticks never raise it.
- Push/pop on the same cycle with `count`=5: `count` stays 5 and the head advances correctly. `rd_en` while empty: no change.
- Assert `rst` low asynchronously mid-stream with `count`=9 and `overrun`=1: all outputs go to reset values without waiting for a clock edge.
